// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and constants for the multiplier issue controller.
package mul_issue_ctrl_pkg;

  localparam int unsigned OpW           = 32;
  localparam int unsigned ProdW         = 64;
  localparam int unsigned DefTimeoutCyc = 40;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StHold,
    StDrain
  } mul_state_e;

endpackage

// File: rtl/mul_opnd_fifo.sv
// Single-clock synchronous FIFO holding operand pairs; Depth must be a power of two.
module mul_opnd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign full  = (cnt_q == (PtrW + 1)'(Depth));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the empty flag guards stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller feeding a shift-add multiplier from an operand FIFO.
// Define MUL_TIMEOUT_EN to add the completion watchdog and the err_timeout port.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OpW-1:0]   in_a,
  input  logic [OpW-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ProdW-1:0] out_prod,
  output logic             mul_start,
  output logic [OpW-1:0]   mul_ain,
  output logic [OpW-1:0]   mul_bin,
  input  logic [ProdW-1:0] mul_yout,
  input  logic             mul_done,
`ifdef MUL_TIMEOUT_EN
  output logic             err_timeout,
`endif
  output logic             busy,
  output logic [15:0]      op_count
);

  mul_state_e       state_q, state_d;
  logic [2*OpW-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [OpW-1:0]   ain_q, bin_q;
  logic [ProdW-1:0] base_q, prod_q, out_prod_q;
  logic             start_q, out_valid_q, rdy_en_q;
  logic [15:0]      op_count_q;
  logic             do_done, do_timeout, do_emit, out_hs;

  assign fifo_push = in_valid & in_ready;
  assign out_hs    = out_valid_q & out_ready;

  mul_opnd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (2 * OpW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            err_q;
  logic            tmo_hit;

  assign tmo_hit     = (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  // Counts cycles since start rise; the LOAD cycle counts as the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (fifo_pop) begin
        tmo_cnt_q <= '0;
      end else if ((state_q == StLoad) || (state_q == StWait)) begin
        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      end
      if (do_timeout) err_q <= 1'b1;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    do_emit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: state_d = StWait;
      StWait: begin
        if (mul_done) begin
          do_done = 1'b1;
          state_d = StHold;
        end else if (tmo_hit) begin
          do_timeout = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (!out_valid_q || out_ready) begin
          do_emit = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ain_q       <= '0;
      bin_q       <= '0;
      base_q      <= '0;
      prod_q      <= '0;
      out_prod_q  <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      if (fifo_pop) begin
        {ain_q, bin_q} <= fifo_rdata;
        base_q         <= mul_yout;
        start_q        <= 1'b1;
      end
      // The multiplier accumulates into yout, so the product is the delta since start.
      if (do_done)    prod_q <= mul_yout - base_q;
      if (do_timeout) prod_q <= '0;
      if (do_emit) begin
        out_prod_q  <= prod_q;
        out_valid_q <= 1'b1;
        start_q     <= 1'b0;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
      if (out_hs) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign in_ready  = rdy_en_q & ~fifo_full;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign mul_start = start_q;
  assign mul_ain   = ain_q;
  assign mul_bin   = bin_q;
  assign op_count  = op_count_q;
  assign busy      = ~fifo_empty | (state_q != StIdle);

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: operand-pair FIFO entries, power of two, minimum 2.
REQ-002 Parameter TIMEOUT_CYC, default 40: maximum cycles from mul_start rise to mul_done.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid/in_ready  in/out  1/1  operand-pair handshake; a transfer occurs when both are high at a rising edge.
REQ-006 in_a, in_b  in  32 each  multiplicand and multiplier.
REQ-007 out_valid/out_ready  out/in  1/1  product handshake.
REQ-008 out_prod  out  64  unsigned product in_a*in_b.
REQ-009 mul_start  out  1  level start to the shift-add multiplier.
REQ-010 mul_ain, mul_bin  out  32 each  operands to the multiplier.
REQ-011 mul_yout  in  64  multiplier product register.
REQ-012 mul_done  in  1  multiplier completion pulse.
REQ-013 busy  out  1  high whenever the FIFO is non-empty or the FSM is not IDLE.
REQ-014 op_count  out  16  count of products delivered on out; wraps 0xFFFF->0.
REQ-015 err_timeout  out  1  sticky timeout flag; present only with MUL_TIMEOUT_EN.

Function
REQ-016 Multiplier contract: it latches ain/bin on the first edge with start high, pulses done about 33 cycles later, holds yout stable while start stays high, and restarts only after start is low for at least one edge.
REQ-017 mul_yout is not cleared between operations; out_prod SHALL be (mul_yout at done) minus (mul_yout captured at start rise), modulo 2^64.
REQ-018 FIFO: in_ready = not full; push on handshake; pop on IDLE->LOAD; simultaneous push and pop when full is not possible because in_ready is low.
REQ-019 FSM states are IDLE, LOAD, WAIT, HOLD, DRAIN.
REQ-020 IDLE->LOAD when the FIFO is non-empty; same edge: pop to mul_ain/mul_bin, capture base=mul_yout, assert mul_start.
REQ-021 LOAD->WAIT after one cycle; mul_start, mul_ain and mul_bin are held stable through LOAD, WAIT and HOLD.
REQ-022 WAIT->HOLD when mul_done is sampled high; the product is computed from mul_yout on that edge.
REQ-023 HOLD: if out_valid is low or out_ready is high, load out_prod, set out_valid, then go to DRAIN on the same edge; otherwise stay in HOLD with mul_start high.
REQ-024 DRAIN: mul_start low for exactly one cycle, then IDLE.
REQ-025 out_valid clears on out_ready&&out_valid unless a new product loads on the same edge.
REQ-026 op_count increments on each out handshake.
REQ-027 Latency: push to mul_start rise is 1 cycle when idle; mul_done sampled to out_valid is 1 cycle; issue-to-issue is done latency+3 cycles minimum.
REQ-028 mul_done is ignored outside WAIT.

Reset
REQ-029 On rst_n low: FSM=IDLE, FIFO empty, and all outputs 0 (in_ready=1 once the FIFO is empty and out of reset); err_timeout=0.
REQ-030 Reset mid-operation discards the queued pairs and the in-flight result without emitting any output.

Configuration
REQ-031 With MUL_TIMEOUT_EN defined: a cycle counter runs in LOAD/WAIT; on reaching TIMEOUT_CYC it sets err_timeout, emits out_prod=0 with out_valid, and proceeds via HOLD/DRAIN.
REQ-032 Without MUL_TIMEOUT_EN: no counter and no err_timeout port; WAIT waits indefinitely.

Structure
REQ-033 A shared package holds the FSM state enum, the operand width (32), the product width (64) and the default TIMEOUT_CYC.
REQ-034 The FIFO is a sub-module mul_opnd_fifo (sync, single-clock, full/empty flags); the FSM and subtractor stay in the top.

Verification
REQ-035 Bench uses the real multiplier: push (3,5) -> out_prod=15, op_count=1.
REQ-036 Push (0xFFFFFFFF,0xFFFFFFFF) after a prior nonzero op -> out_prod=0xFFFFFFFE00000001 (delta rule on stale yout).
REQ-037 Push 6 pairs back-to-back with FIFO_DEPTH=4 -> in_ready low after 5 accepted, all 6 products correct and in order.
REQ-038 out_ready held low for 100 cycles across two ops -> first product held, second stalled in HOLD with mul_start high; both correct after release.
REQ-039 mul_done tied 0, MUL_TIMEOUT_EN -> err_timeout=1 and out_prod=0 at 40 cycles after start.
REQ-040 rst_n pulsed low mid-WAIT with 2 pairs queued -> no out_valid, busy=0, next push (7,9) -> 63.
